// File: rtl/ext_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ext_arbiter
// Brief    : Round-robin arbiter sharing one immediate extender between two
//            requesters; result held in a one-entry valid/ready register.
//            Optional grant counters are enabled by EXT_ARB_STATS_EN.
// Revision : 1.0
// ============================================================================
module ext_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [15:0]      imm0,
    input  logic [15:0]      imm1,
    input  logic [1:0]       eop0,
    input  logic [1:0]       eop1,
    output logic             ack0,
    output logic             ack1,
    output logic [15:0]      ext_imm,
    output logic [1:0]       ext_eop,
    input  logic [31:0]      ext_result,
    output logic             out_valid,
    output logic             out_id,
    output logic [31:0]      out_ext,
    input  logic             out_ready,
    input  logic             stats_clr,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    logic        r_out_valid;
    logic        r_out_id;
    logic [31:0] r_out_ext;
    logic        r_prio;

    logic w_slot_free;
    logic w_winner;
    logic w_grant;

    assign w_slot_free = !r_out_valid || out_ready;
    // Priority pointer only matters on a tie; a lone requester always wins.
    assign w_winner    = (req0 && req1) ? r_prio : req1;
    assign w_grant     = rst_n && w_slot_free && (req0 || req1);

    assign ack0    = w_grant && !w_winner;
    assign ack1    = w_grant &&  w_winner;
    assign ext_imm = w_grant ? (w_winner ? imm1 : imm0) : 16'h0;
    assign ext_eop = w_grant ? (w_winner ? eop1 : eop0) : 2'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_id    <= 1'b0;
            r_out_ext   <= 32'h0;
            r_prio      <= 1'b0;
        end else if (w_grant) begin
            r_out_valid <= 1'b1;
            r_out_id    <= w_winner;
            r_out_ext   <= ext_result;
            r_prio      <= ~w_winner;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_id    = r_out_id;
    assign out_ext   = r_out_ext;

`ifdef EXT_ARB_STATS_EN
    logic [CNT_W-1:0] r_cnt0;
    logic [CNT_W-1:0] r_cnt1;

    // Clear wins over increment; counters stick at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else if (stats_clr) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (ack0 && (r_cnt0 != {CNT_W{1'b1}}))
                r_cnt0 <= r_cnt0 + CNT_W'(1);
            if (ack1 && (r_cnt1 != {CNT_W{1'b1}}))
                r_cnt1 <= r_cnt1 + CNT_W'(1);
        end
    end

    assign cnt0 = r_cnt0;
    assign cnt1 = r_cnt1;
`else
    logic w_unused_stats_clr;
    assign w_unused_stats_clr = stats_clr;
    assign cnt0 = '0;
    assign cnt1 = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ext_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ext_arbiter
// Brief    : Directed self-checking bench for ext_arbiter with a per-cycle
//            reference model and hand-computed literal expectations.
// Revision : 1.0
// ============================================================================
module tb_ext_arbiter;

    localparam int CNT_W = 2;

    logic             clk;
    logic             rst_n;
    logic             req0, req1;
    logic [15:0]      imm0, imm1;
    logic [1:0]       eop0, eop1;
    logic             ack0, ack1;
    logic [15:0]      ext_imm;
    logic [1:0]       ext_eop;
    logic [31:0]      ext_result;
    logic             out_valid;
    logic             out_id;
    logic [31:0]      out_ext;
    logic             out_ready;
    logic             stats_clr;
    logic [CNT_W-1:0] cnt0, cnt1;

    int errors = 0;
    int checks = 0;

    ext_arbiter #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1),
        .imm0(imm0), .imm1(imm1),
        .eop0(eop0), .eop1(eop1),
        .ack0(ack0), .ack1(ack1),
        .ext_imm(ext_imm), .ext_eop(ext_eop),
        .ext_result(ext_result),
        .out_valid(out_valid), .out_id(out_id), .out_ext(out_ext),
        .out_ready(out_ready),
        .stats_clr(stats_clr),
        .cnt0(cnt0), .cnt1(cnt1)
    );

    function automatic logic [31:0] extend(input logic [15:0] imm, input logic [1:0] eop);
        case (eop)
            2'd0:    return {16'h0, imm};
            2'd1:    return {{16{imm[15]}}, imm};
            2'd2:    return {imm, 16'h0};
            default: return {{14{imm[15]}}, imm, 2'b00};
        endcase
    endfunction

    // Stand-in for the shared extender outside the arbiter.
    always_comb ext_result = extend(ext_imm, ext_eop);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state: contents of the output slot, tie pointer, grant totals.
    logic        m_valid, m_id, m_prio;
    logic [31:0] m_ext;
    int          m_cnt0, m_cnt1;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_valid = 1'b0; m_id = 1'b0; m_prio = 1'b0; m_ext = 32'h0;
            m_cnt0 = 0; m_cnt1 = 0;
        end else begin
            logic can_take, who, e0, e1;
            logic [15:0] wimm;
            logic [1:0]  weop;
            can_take = (!m_valid || out_ready) && (req0 || req1);
            if (req0 && req1) who = m_prio;
            else              who = req1;
            e0   = can_take && (who == 1'b0);
            e1   = can_take && (who == 1'b1);
            wimm = !can_take ? 16'h0 : (who ? imm1 : imm0);
            weop = !can_take ? 2'b0  : (who ? eop1 : eop0);

            chk("ack0",      {31'h0, ack0},      {31'h0, e0});
            chk("ack1",      {31'h0, ack1},      {31'h0, e1});
            chk("ext_imm",   {16'h0, ext_imm},   {16'h0, wimm});
            chk("ext_eop",   {30'h0, ext_eop},   {30'h0, weop});
            chk("out_valid", {31'h0, out_valid}, {31'h0, m_valid});
            chk("out_id",    {31'h0, out_id},    {31'h0, m_id});
            chk("out_ext",   out_ext,            m_ext);
            chk("cnt0",      32'(cnt0),          32'(m_cnt0));
            chk("cnt1",      32'(cnt1),          32'(m_cnt1));

            if (can_take) begin
                m_ext   = extend(wimm, weop);
                m_id    = who;
                m_valid = 1'b1;
                m_prio  = ~who;
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
`ifdef EXT_ARB_STATS_EN
            if (stats_clr) begin
                m_cnt0 = 0; m_cnt1 = 0;
            end else begin
                if (e0 && m_cnt0 < CNT_MAX) m_cnt0++;
                if (e1 && m_cnt1 < CNT_MAX) m_cnt1++;
            end
`endif
        end
    end

    task automatic mid();  @(negedge clk); #1; endtask
    task automatic next(); @(posedge clk); #1; endtask

    task automatic drive(input logic r0, input logic [15:0] i0, input logic [1:0] e0,
                         input logic r1, input logic [15:0] i1, input logic [1:0] e1,
                         input logic rdy);
        req0 = r0; imm0 = i0; eop0 = e0;
        req1 = r1; imm1 = i1; eop1 = e1;
        out_ready = rdy;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        next();
        rst_n = 1'b1;
    endtask

    int exp_sat;

    initial begin
        rst_n = 1'b0; stats_clr = 1'b0;
        drive(0, 16'h0, 2'd0, 0, 16'h0, 2'd0, 1'b0);
`ifdef EXT_ARB_STATS_EN
        exp_sat = 3;
`else
        exp_sat = 0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", {31'h0, out_valid}, 32'h0);
        chk("reset out_ext", out_ext, 32'h0);
        rst_n = 1'b1;

        // Single request, sign-extend then shift left by two
        drive(1, 16'hf000, 2'd3, 0, 16'h0, 2'd0, 1'b1);
        mid(); chk("t1 ack0", {31'h0, ack0}, 32'h1);
        next(); drive(0, 16'h0, 2'd0, 0, 16'h0, 2'd0, 1'b1);
        mid();
        chk("t1 valid", {31'h0, out_valid}, 32'h1);
        chk("t1 id", {31'h0, out_id}, 32'h0);
        chk("t1 ext", out_ext, 32'hffffc000);
        next();

        // Both requesting every cycle from a fresh pointer
        do_reset();
        drive(1, 16'hf000, 2'd1, 1, 16'h8001, 2'd0, 1'b1);
        mid(); chk("t2 c1 ack0", {31'h0, ack0}, 32'h1);
        next(); mid();
        chk("t2 c2 ack1", {31'h0, ack1}, 32'h1);
        chk("t2 c2 ext", out_ext, 32'hfffff000);
        next(); mid();
        chk("t2 c3 ack0", {31'h0, ack0}, 32'h1);
        chk("t2 c3 ext", out_ext, 32'h00008001);
        chk("t2 c3 id", {31'h0, out_id}, 32'h1);
        next(); mid(); chk("t2 c4 ack1", {31'h0, ack1}, 32'h1);
        next();

        // Backpressure holds the slot and blocks requester 0
        drive(0, 16'h0, 2'd0, 1, 16'h1234, 2'd2, 1'b1);
        next();
        drive(1, 16'h0055, 2'd0, 0, 16'h0, 2'd0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            mid();
            chk("t3 no ack0", {31'h0, ack0}, 32'h0);
            chk("t3 hold ext", out_ext, 32'h12340000);
            chk("t3 hold id", {31'h0, out_id}, 32'h1);
            next();
        end
        out_ready = 1'b1;
        mid(); chk("t3 ack0 on ready", {31'h0, ack0}, 32'h1);
        next();

        // Streaming with ready toggling 1,0,1
        drive(1, 16'h0001, 2'd1, 0, 16'h0, 2'd0, 1'b1);
        next();
        drive(1, 16'h0002, 2'd0, 0, 16'h0, 2'd0, 1'b0);
        mid(); chk("t4 pop+grant valid", {31'h0, out_valid}, 32'h1);
        chk("t4 ext", out_ext, 32'h00000001);
        next();
        out_ready = 1'b1;
        mid(); chk("t4 ack0", {31'h0, ack0}, 32'h1);
        next();
        drive(0, 16'h0, 2'd0, 0, 16'h0, 2'd0, 1'b1);
        mid(); chk("t4 last ext", out_ext, 32'h00000002);
        next(); mid(); chk("t4 drained", {31'h0, out_valid}, 32'h0);
        next();

        // Asynchronous reset mid-stream, then a lone requester 1
        drive(1, 16'h7777, 2'd0, 0, 16'h0, 2'd0, 1'b1);
        next();
        mid();
        rst_n = 1'b0;
        #1;
        chk("t5 rst valid", {31'h0, out_valid}, 32'h0);
        chk("t5 rst ext", out_ext, 32'h0);
        chk("t5 rst ack0", {31'h0, ack0}, 32'h0);
        chk("t5 rst cnt0", 32'(cnt0), 32'h0);
        next();
        @(negedge clk);
        next();
        rst_n = 1'b1;
        drive(0, 16'h0, 2'd0, 1, 16'h00aa, 2'd0, 1'b1);
        mid(); chk("t5 ack1 first", {31'h0, ack1}, 32'h1);
        next();

        // Five grants to requester 0, then a clear pulse
        drive(1, 16'h0003, 2'd0, 0, 16'h0, 2'd0, 1'b1);
        repeat (5) next();
        drive(0, 16'h0, 2'd0, 0, 16'h0, 2'd0, 1'b1);
        mid(); chk("t6 cnt0 sat", 32'(cnt0), 32'(exp_sat));
        next();
        stats_clr = 1'b1;
        next();
        stats_clr = 1'b0;
        mid(); chk("t6 cnt0 clr", 32'(cnt0), 32'h0);
        next();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
`default_nettype wire
